fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode/control logic.
- Drives a synchronous instruction ROM with one-cycle read latency and absorbs decode stalls with a one-entry skid buffer, so throughput stays at one instruction per cycle.
- Handles PC redirects from EX for taken branches, JAL and JALR.
- Presents a registered PC, PC+4, instruction and valid bit to decode.

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-entry skid buffer and IF/ID register.
// Define FETCH_PERF_EN to add the fetch/bubble performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic        o_if_vld,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic [31:0] o_if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_bubble_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  logic        sk_vld_q, sk_vld_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic        if_vld_q, if_vld_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;

  always_comb begin
    pc_d       = pc_q;
    rsp_vld_d  = 1'b0;
    rsp_pc_d   = rsp_pc_q;
    sk_vld_d   = sk_vld_q;
    sk_pc_d    = sk_pc_q;
    sk_instr_d = sk_instr_q;
    if_vld_d   = if_vld_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;

    if (i_redirect) begin
      // Redirect wins over stall: flush skid and any outstanding response.
      sk_vld_d   = 1'b0;
      if_vld_d   = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (i_stall) begin
      // Request rule guarantees the skid is empty whenever a response lands here.
      if (rsp_vld_q) begin
        sk_vld_d   = 1'b1;
        sk_pc_d    = rsp_pc_q;
        sk_instr_d = i_imem_rdata;
      end
    end else if (sk_vld_q) begin
      if_vld_d   = 1'b1;
      if_pc_d    = sk_pc_q;
      if_pc4_d   = sk_pc_q + 32'd4;
      if_instr_d = sk_instr_q;
      if (rsp_vld_q) begin
        sk_pc_d    = rsp_pc_q;
        sk_instr_d = i_imem_rdata;
      end else begin
        sk_vld_d = 1'b0;
      end
    end else if (rsp_vld_q) begin
      if_vld_d   = 1'b1;
      if_pc_d    = rsp_pc_q;
      if_pc4_d   = rsp_pc_q + 32'd4;
      if_instr_d = i_imem_rdata;
    end else begin
      if_vld_d   = 1'b0;
      if_instr_d = NOP_INSTR;
    end

    // Only request when the response is guaranteed a free slot next cycle.
    o_imem_req  = i_redirect | ~sk_vld_d;
    o_imem_addr = i_redirect ? i_redirect_pc : pc_q;
    if (o_imem_req) begin
      pc_d      = o_imem_addr + 32'd4;
      rsp_vld_d = 1'b1;
      rsp_pc_d  = o_imem_addr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q       <= RESET_PC;
      rsp_vld_q  <= 1'b0;
      rsp_pc_q   <= 32'd0;
      sk_vld_q   <= 1'b0;
      sk_pc_q    <= 32'd0;
      sk_instr_q <= NOP_INSTR;
      if_vld_q   <= 1'b0;
      if_pc_q    <= 32'd0;
      if_pc4_q   <= 32'd4;
      if_instr_q <= NOP_INSTR;
    end else begin
      pc_q       <= pc_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_pc_q   <= rsp_pc_d;
      sk_vld_q   <= sk_vld_d;
      sk_pc_q    <= sk_pc_d;
      sk_instr_q <= sk_instr_d;
      if_vld_q   <= if_vld_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign o_if_vld   = if_vld_q;
  assign o_if_pc    = if_pc_q;
  assign o_if_pc4   = if_pc4_q;
  assign o_if_instr = if_instr_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        if_load;

  // IF/ID is (re)loaded on every edge except a plain stall.
  assign if_load = i_redirect | ~i_stall;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (if_load) begin
      if (if_vld_d) fetch_cnt_d  = fetch_cnt_q + 32'd1;
      else          bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_perf_fetch_cnt  = fetch_cnt_q;
  assign o_perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic
// against a program-order reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic [31:0] rom_rdata = 32'd0;
  logic        o_if_vld;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc4;
  logic [31:0] o_if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_f;
  logic [31:0] perf_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what IF/ID must hold, and the next program-order PC to deliver.
  logic        exp_vld;
  logic [31:0] exp_pc, exp_pc4, exp_instr, next_pc;
  logic        first_edge;
  logic [31:0] exp_fetch, exp_bubble;

  fetch_stage dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (rom_rdata),
    .o_if_vld      (o_if_vld),
    .o_if_pc       (o_if_pc),
    .o_if_pc4      (o_if_pc4),
    .o_if_instr    (o_if_instr)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetch_cnt  (perf_f),
    .o_perf_bubble_cnt (perf_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous ROM with one-cycle read latency.
  always @(posedge clk) if (o_imem_req) rom_rdata <= rom_word(o_imem_addr);

  task automatic model_reset();
    exp_vld    = 1'b0;
    exp_pc     = 32'd0;
    exp_pc4    = 32'd4;
    exp_instr  = NOP;
    next_pc    = 32'd0;
    first_edge = 1'b1;
    exp_fetch  = 32'd0;
    exp_bubble = 32'd0;
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    model_reset();
    i_reset = 1'b0;
  endtask

  // Drive one cycle, advance past the edge, and update the expected IF/ID contents.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    i_stall = st;
    i_redirect = rd;
    i_redirect_pc = tgt;
    @(posedge clk);
    #1;
    if (rd) begin
      exp_vld = 1'b0;
      exp_instr = NOP;
      next_pc = tgt;
      exp_bubble++;
    end else if (st) begin
      // IF/ID holds
    end else if (first_edge) begin
      exp_vld = 1'b0;
      exp_instr = NOP;
      exp_bubble++;
    end else begin
      exp_vld = 1'b1;
      exp_pc = next_pc;
      exp_pc4 = next_pc + 32'd4;
      exp_instr = rom_word(next_pc);
      next_pc = next_pc + 32'd4;
      exp_fetch++;
    end
    first_edge = 1'b0;
    i_stall = 1'b0;
    i_redirect = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3);
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_if_vld, o_if_pc, o_if_pc4, o_if_instr} !== {1'b0, 32'd0, 32'd4, NOP}) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%0b pc=%h pc4=%h instr=%h want 0/0/4/13",
               o_if_vld, o_if_pc, o_if_pc4, o_if_instr);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if ({o_imem_req, o_imem_addr} !== {1'b1, 32'(4 * k)}) begin
        n_fail++;
        $display("FAIL stream_addr: got req=%0b addr=%h want 1/%h", o_imem_req, o_imem_addr,
                 32'(4 * k));
      end
      cycle(1'b0, 1'b0, 32'd0);
      n_checks++;
      if (k == 0) begin
        if ({o_if_vld, o_if_instr} !== {1'b0, NOP}) begin
          n_fail++;
          $display("FAIL stream_first_bubble: got vld=%0b instr=%h", o_if_vld, o_if_instr);
        end
      end else if ({o_if_vld, o_if_pc, o_if_pc4, o_if_instr} !==
                   {1'b1, 32'(4 * (k - 1)), 32'(4 * k), 32'h1000_0000 + 32'(k - 1)}) begin
        n_fail++;
        $display("FAIL stream_data: got vld=%0b pc=%h pc4=%h instr=%h at k=%0d",
                 o_if_vld, o_if_pc, o_if_pc4, o_if_instr, k);
      end
    end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 3; s++) begin
      i_stall = 1'b1;
      #1;
      n_checks++;
      if (o_imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_req: got req=%0b want 0 at stall cycle %0d", o_imem_req, s);
      end
      cycle(1'b1, 1'b0, 32'd0);
      n_checks++;
      if ({o_if_vld, o_if_pc, o_if_instr} !== {1'b1, 32'd8, 32'h1000_0002}) begin
        n_fail++;
        $display("FAIL stall_hold: got vld=%0b pc=%h instr=%h want 1/8/10000002",
                 o_if_vld, o_if_pc, o_if_instr);
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 32'd0);
      n_checks++;
      if ({o_if_vld, o_if_pc, o_if_instr} !== {1'b1, 32'(12 + 4 * k), 32'h1000_0003 + 32'(k)})
      begin
        n_fail++;
        $display("FAIL stall_release: got vld=%0b pc=%h instr=%h at k=%0d",
                 o_if_vld, o_if_pc, o_if_instr, k);
      end
    end
  endtask

  task automatic test_redirect();
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    n_checks++;
    if ({o_if_vld, o_if_pc} !== {1'b1, 32'h20}) begin
      n_fail++;
      $display("FAIL redir_setup: got vld=%0b pc=%h want 1/20", o_if_vld, o_if_pc);
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    #1;
    n_checks++;
    if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL redir_issue: got req=%0b addr=%h want 1/100", o_imem_req, o_imem_addr);
    end
    cycle(1'b0, 1'b1, 32'h100);
    n_checks++;
    if ({o_if_vld, o_if_instr} !== {1'b0, NOP}) begin
      n_fail++;
      $display("FAIL redir_bubble: got vld=%0b instr=%h want 0/13", o_if_vld, o_if_instr);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 32'd0);
      n_checks++;
      if ({o_if_vld, o_if_pc, o_if_instr} !== {1'b1, 32'h100 + 32'(4 * k), 32'h1000_0040 + 32'(k)})
      begin
        n_fail++;
        $display("FAIL redir_target: got vld=%0b pc=%h instr=%h at k=%0d",
                 o_if_vld, o_if_pc, o_if_instr, k);
      end
    end
  endtask

  task automatic test_redirect_stall();
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h200);
    n_checks++;
    if ({o_if_vld, o_if_instr} !== {1'b0, NOP}) begin
      n_fail++;
      $display("FAIL rs_bubble: got vld=%0b instr=%h want 0/13", o_if_vld, o_if_instr);
    end
    cycle(1'b1, 1'b0, 32'd0);
    n_checks++;
    if (o_if_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_hold_bubble: got vld=%0b want 0", o_if_vld);
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, 32'd0);
      n_checks++;
      if ({o_if_vld, o_if_pc, o_if_instr} !== {1'b1, 32'h200 + 32'(4 * k), 32'h1000_0080 + 32'(k)})
      begin
        n_fail++;
        $display("FAIL rs_target: got vld=%0b pc=%h instr=%h at k=%0d",
                 o_if_vld, o_if_pc, o_if_instr, k);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 32'd0);
    i_stall = 1'b1;
    #2;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_if_vld, o_if_pc, o_if_pc4, o_if_instr} !== {1'b0, 32'd0, 32'd4, NOP}) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%0b pc=%h pc4=%h instr=%h want 0/0/4/13",
               o_if_vld, o_if_pc, o_if_pc4, o_if_instr);
    end
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 32'd0);
      n_checks++;
      if (k == 0) begin
        if ({o_if_vld, o_if_instr} !== {1'b0, NOP}) begin
          n_fail++;
          $display("FAIL restart_bubble: got vld=%0b instr=%h", o_if_vld, o_if_instr);
        end
      end else if ({o_if_vld, o_if_pc, o_if_instr} !==
                   {1'b1, 32'(4 * (k - 1)), 32'h1000_0000 + 32'(k - 1)}) begin
        n_fail++;
        $display("FAIL restart_data: got vld=%0b pc=%h instr=%h at k=%0d",
                 o_if_vld, o_if_pc, o_if_instr, k);
      end
    end
  endtask

  task automatic test_random();
    logic        st, rd;
    logic [31:0] tgt;
    int          r;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      r  = $urandom_range(0, 9);
      if (r == 0)      tgt = 32'hFFFF_FFF8;
      else if (r == 1) tgt = 32'($urandom_range(0, 4095));
      else             tgt = 32'($urandom_range(0, 1023)) << 2;
      cycle(st, rd, tgt);
      n_checks++;
      if ({o_if_vld, o_if_pc, o_if_pc4, o_if_instr} !== {exp_vld, exp_pc, exp_pc4, exp_instr})
      begin
        n_fail++;
        $display("FAIL rand_ifid: n=%0d got %0b/%h/%h/%h want %0b/%h/%h/%h", n,
                 o_if_vld, o_if_pc, o_if_pc4, o_if_instr, exp_vld, exp_pc, exp_pc4, exp_instr);
      end
`ifdef FETCH_PERF_EN
      n_checks++;
      if ({perf_f, perf_b} !== {exp_fetch, exp_bubble}) begin
        n_fail++;
        $display("FAIL rand_perf: n=%0d got %0d/%0d want %0d/%0d", n, perf_f, perf_b,
                 exp_fetch, exp_bubble);
      end
`endif
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset(2);
    repeat (11) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h300);
    cycle(1'b0, 1'b0, 32'd0);
    n_checks++;
    if ({perf_f, perf_b} !== {32'd11, 32'd2}) begin
      n_fail++;
      $display("FAIL perf_counts: got fetch=%0d bubble=%0d want 11/2", perf_f, perf_b);
    end
  endtask
`endif

  initial begin
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'd0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
